oflow_score_calc_multi_channel_fsm: RTL and testbench

// - Sequences the similarity-metric engines during score calculation. Generalises the fixed 2-channel control to NUM_CH channels.
// - Each round: starts every enabled channel, waits until all of them report done, then repeats until the buffer signals done_read.
// - New over the 2-channel block: per-channel done aggregation, a round counter, an abort input, an explicit done pulse and error flagging.
// - Sits between the registration controller, the ID buffer and the NUM_CH similarity-metric units.
//

---
 rtl/oflow_score_calc_multi_channel_fsm.sv | 90 +++++++++
 tb/tb_oflow_score_calc_multi_channel_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/oflow_score_calc_multi_channel_fsm.sv
// oflow_score_calc_multi_channel_fsm: runs rounds of NUM_CH similarity-metric engines until the buffer read finishes
module oflow_score_calc_multi_channel_fsm #(
  parameter int NUM_CH = 2,
  parameter int ID_LEN = 12,
  parameter int RND_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_N,
  input  logic                     start_score_calc,
  input  logic                     abort,
  input  logic                     done_read,
  input  logic [NUM_CH*ID_LEN-1:0] id_vec,
  input  logic [NUM_CH-1:0]        done_similarity_metric,
  output logic [NUM_CH-1:0]        start_similarity_metric,
  output logic                     busy,
  output logic                     done_score_calc,
  output logic [RND_W-1:0]         round_cnt,
  output logic                     err_unexpected_done
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, FIN = 2'd3;
  logic [1:0] state;
  logic [NUM_CH-1:0] en_mask, done_mask, id_en, good, next_mask;
  logic last, accept, complete, err_hit, finish;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_en
      if (c == 0) begin : g_first
        assign id_en[c] = 1'b1;
      end else begin : g_rest
        assign id_en[c] = |id_vec[c*ID_LEN +: ID_LEN];
      end
    end
  endgenerate
  // a done only counts if it is still awaited in the current round
  assign good      = done_similarity_metric & en_mask & ~done_mask;
  assign next_mask = done_mask | good;
  assign complete  = state == WAIT && next_mask == en_mask;
  assign finish    = last || done_read;
  assign accept    = state == IDLE && start_score_calc && !abort;
  assign err_hit   = |done_similarity_metric &&
                     (state != WAIT || |(done_similarity_metric & ~en_mask) || |(done_similarity_metric & done_mask));
  assign start_similarity_metric = state == START ? en_mask : '0;
  assign busy            = state != IDLE;
  assign done_score_calc = state == FIN;
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state               <= IDLE;
      en_mask             <= '0;
      done_mask           <= '0;
      last                <= 1'b0;
      round_cnt           <= '0;
      err_unexpected_done <= 1'b0;
    end else begin
      err_unexpected_done <= accept ? 1'b0 : (err_hit ? 1'b1 : err_unexpected_done);
      if (accept)
        round_cnt <= '0;
      else if (complete && !abort && round_cnt != {RND_W{1'b1}})
        round_cnt <= round_cnt + RND_W'(1);
      if (abort) begin
        state     <= IDLE;
        done_mask <= '0;
        last      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            last <= 1'b0;
            if (start_score_calc) begin
              state   <= START;
              en_mask <= id_en;
            end
          end
          START: begin
            done_mask <= '0;
            last      <= finish;
            state     <= WAIT;
          end
          WAIT: begin
            done_mask <= next_mask;
            last      <= finish;
            if (complete) begin
              state   <= finish ? FIN : START;
              en_mask <= finish ? en_mask : id_en;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oflow_score_calc_multi_channel_fsm.sv
// tb_oflow_score_calc_multi_channel_fsm: directed rounds checked each cycle against a round-level model
module tb_oflow_score_calc_multi_channel_fsm;
  localparam int N = 4, L = 12, R = 2;
  logic clk = 1'b0, reset_N = 1'b0;
  logic start_score_calc = 1'b0, abort = 1'b0, done_read = 1'b0;
  logic [N*L-1:0] id_vec = '0;
  logic [N-1:0] done_similarity_metric = '0;
  logic [N-1:0] start_similarity_metric;
  logic busy, done_score_calc, err_unexpected_done;
  logic [R-1:0] round_cnt;
  int total = 0, bad = 0, n_start = 0, n_done = 0, b_start, b_done;

  oflow_score_calc_multi_channel_fsm #(.NUM_CH(N), .ID_LEN(L), .RND_W(R)) dut (
    .clk(clk), .reset_N(reset_N), .start_score_calc(start_score_calc), .abort(abort),
    .done_read(done_read), .id_vec(id_vec), .done_similarity_metric(done_similarity_metric),
    .start_similarity_metric(start_similarity_metric), .busy(busy), .done_score_calc(done_score_calc),
    .round_cnt(round_cnt), .err_unexpected_done(err_unexpected_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic dr, input logic [N-1:0] dn);
    start_score_calc = st;
    abort = ab;
    done_read = dr;
    done_similarity_metric = dn;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] enables(input logic [N*L-1:0] v);
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = (i == 0) || (v[i*L +: L] != '0);
    return e;
  endfunction

  // model: busy run split into "pulse cycle", "awaiting channels" and "finish cycle"
  logic m_busy, m_st, m_fin, m_last, m_err, waiting, accepted, stray;
  logic [N-1:0] m_en, m_need;
  int m_rounds;
  always @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      m_busy = 0; m_st = 0; m_fin = 0; m_last = 0; m_err = 0;
      m_en = '0; m_need = '0; m_rounds = 0;
    end else begin
      waiting  = m_busy && !m_st && !m_fin;
      accepted = !m_busy && start_score_calc && !abort;
      stray    = |(done_similarity_metric & ~(waiting ? m_need : '0));
      if (accepted) m_err = 0;
      else if (stray) m_err = 1;
      if (abort) begin
        m_busy = 0; m_st = 0; m_fin = 0; m_last = 0;
      end else if (!m_busy) begin
        if (start_score_calc) begin
          m_busy = 1; m_st = 1; m_last = 0; m_rounds = 0;
          m_en = enables(id_vec); m_need = m_en;
        end
      end else if (m_st) begin
        m_st = 0;
        m_last = m_last | done_read;
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0;
      end else begin
        m_need = m_need & ~done_similarity_metric;
        m_last = m_last | done_read;
        if (m_need == '0) begin
          m_rounds++;
          if (m_last) m_fin = 1;
          else begin
            m_st = 1; m_en = enables(id_vec); m_need = m_en;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("start_pulse", start_similarity_metric, m_st ? m_en : '0);
    chk("busy", busy, m_busy);
    chk("done_pulse", done_score_calc, m_fin);
    chk("round_cnt", round_cnt, m_rounds > 3 ? 3 : m_rounds);
    chk("err", err_unexpected_done, m_err);
    if (start_similarity_metric != '0) n_start++;
    if (done_score_calc) n_done++;
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_start", start_similarity_metric, 0);
    chk("rst_rc", round_cnt, 0);
    reset_N = 1'b1;
    // one round, channels 0,1,3 enabled, dones spread out
    id_vec = {12'd3, 12'd0, 12'd5, 12'd0};
    b_start = n_start; b_done = n_done;
    step(1, 0, 0, 0);
    chk("t1_pulses", start_similarity_metric, 4'b1011);
    step(0, 0, 1, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 4'b0010);
    step(0, 0, 0, 0);
    chk("t1_wait_busy", busy, 1);
    step(0, 0, 0, 4'b1000);
    chk("t1_done", done_score_calc, 1);
    chk("t1_rc", round_cnt, 1);
    step(0, 0, 0, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nstart", n_start - b_start, 1);
    chk("t1_ndone", n_done - b_done, 1);
    // three single-channel rounds
    id_vec = '0;
    b_start = n_start; b_done = n_done;
    step(1, 0, 0, 0);
    chk("t2_pulses", start_similarity_metric, 4'b0001);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 4'b0001);
    chk("t2_rc", round_cnt, 3);
    step(0, 0, 0, 0);
    chk("t2_nstart", n_start - b_start, 3);
    chk("t2_ndone", n_done - b_done, 1);
    // five rounds saturate the 2-bit counter
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      step(0, 0, 0, 4'b0001);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 4'b0001);
    chk("t3_sat", round_cnt, 3);
    step(0, 0, 0, 0);
    // all dones plus done_read in one cycle
    id_vec = {12'd3, 12'd0, 12'd5, 12'd0};
    b_start = n_start;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 4'b1011);
    chk("t4_done", done_score_calc, 1);
    chk("t4_nopulse", start_similarity_metric, 0);
    step(0, 0, 0, 0);
    chk("t4_nstart", n_start - b_start, 1);
    // duplicate and disabled-channel dones
    id_vec = {12'd0, 12'd0, 12'd7, 12'd0};
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 4'b0100);
    chk("t5_err", err_unexpected_done, 1);
    chk("t5_notdone", done_score_calc, 0);
    step(0, 0, 1, 4'b0010);
    chk("t5_done", done_score_calc, 1);
    chk("t5_rc", round_cnt, 1);
    step(0, 0, 0, 0);
    // abort mid-run, then a fresh start
    id_vec = '0;
    b_done = n_done;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 4'b1000);
    chk("t6_err", err_unexpected_done, 1);
    step(0, 1, 0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rc", round_cnt, 1);
    chk("t6_ndone", n_done - b_done, 0);
    step(1, 1, 0, 0);
    chk("t6_abort_wins", busy, 0);
    step(1, 0, 0, 0);
    chk("t6_rc_clr", round_cnt, 0);
    chk("t6_err_clr", err_unexpected_done, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    // asynchronous reset during WAIT
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    chk("t7_pre_rc", round_cnt, 1);
    reset_N = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_rc", round_cnt, 0);
    chk("t7_start", start_similarity_metric, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_N = 1'b1;
    id_vec = {12'd3, 12'd0, 12'd5, 12'd0};
    step(1, 0, 0, 0);
    chk("t7_pulses", start_similarity_metric, 4'b1011);
    step(0, 0, 1, 0);
    step(0, 0, 0, 4'b1011);
    chk("t7_done", done_score_calc, 1);
    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
